// File: rtl/data_route_pkg.sv
// Shared constants and types for the data-route crossbar width adapters.
package data_route_pkg;

    localparam int DIN_W  = 256;
    localparam int RATIO  = 6;
    localparam int DOUT_W = DIN_W * RATIO;

    typedef logic [2:0] lane_idx_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Beats per word; the out-of-range codes 0 and 7 select a full word.
    function automatic lane_idx_t pack_beats(input logic [2:0] pack_num);
        return (pack_num == 3'd0 || pack_num == 3'd7) ? lane_idx_t'(RATIO) : pack_num;
    endfunction

endpackage

// File: rtl/in256_out1536_pack_if.sv
// AXI-Stream bundle (data, valid, ready, last) with producer/consumer views.
interface in256_out1536_pack_if #(
    parameter int W = 256
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/in256_out1536_pack_axis_out_reg.sv
// Single-entry AXIS output register: loads a word when free, holds it stable
// until the downstream handshake.
module axis_out_reg
    import data_route_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_i,
    input  logic [DOUT_W-1:0]           data_i,
    input  logic                        last_i,
    output logic                        free_o,
    in256_out1536_pack_if.master        m_axis
);

    logic [DOUT_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;

    assign free_o = ~tvalid_q | m_axis.tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the wide data register is reset as well, because the bus must read zero during reset.
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_i) begin
            tdata_q  <= data_i;
            tlast_q  <= last_i;
            tvalid_q <= 1'b1;
        end else if (m_axis.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: rtl/in256_out1536_pack.sv
// Up-packs 256-bit AXIS beats into zero-padded 1536-bit words; beats per word
// is latched from pack_num on the first beat of each word.
module in256_out1536_pack
    import data_route_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            pack_num,
    in256_out1536_pack_if.slave   s_axis,
    in256_out1536_pack_if.master  m_axis
);

    pack_state_e       state_q;
    lane_idx_t         cnt_q;
    lane_idx_t         n_q;
    lane_idx_t         n_eff;
    logic              ready_q;
    logic              last_q;
    logic [DOUT_W-1:0] buf_q;
    logic [DOUT_W-1:0] word_d;
    logic [DOUT_W-1:0] load_data;
    logic              load_last;
    logic              accept;
    logic              close;
    logic              free;
    logic              load;

    // Assembly buffer with the incoming beat dropped into lane cnt_q.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
        word_d = buf_q;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == lane_idx_t'(k)) word_d[k*DIN_W +: DIN_W] = s_axis.tdata;
        end
    end

    assign n_eff     = (cnt_q == '0) ? pack_beats(pack_num) : n_q;
    assign accept    = s_axis.tvalid & ready_q;
    assign close     = accept & (s_axis.tlast | (cnt_q == n_eff - 3'd1));
    assign load      = free & ((state_q == HOLD) | close);
    assign load_data = (state_q == HOLD) ? buf_q  : word_d;
    assign load_last = (state_q == HOLD) ? last_q : s_axis.tlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            n_q     <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    ready_q <= 1'b1;
                    if (close) begin
                        cnt_q <= '0;
                        if (free) begin
                            buf_q <= '0;
                        end else begin
                            // Output still occupied: park the finished word and stall input.
                            buf_q   <= word_d;
                            last_q  <= s_axis.tlast;
                            state_q <= HOLD;
                            ready_q <= 1'b0;
                        end
                    end else if (accept) begin
                        buf_q <= word_d;
                        cnt_q <= cnt_q + 3'd1;
                        n_q   <= n_eff;
                    end
                end
                HOLD: begin
                    if (free) begin
                        buf_q   <= '0;
                        state_q <= FILL;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_axis.tready = ready_q;

    axis_out_reg u_out_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .data_i (load_data),
        .last_i (load_last),
        .free_o (free),
        .m_axis (m_axis)
    );

endmodule

// File: tb/tb_in256_out1536_pack.sv
// Bench for in256_out1536_pack: beat-queue reference model, one task per scenario.
module tb_in256_out1536_pack;
    import data_route_pkg::*;

    typedef struct {
        logic [DOUT_W-1:0] data;
        logic              last;
        int                cyc;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] pack_num;

    in256_out1536_pack_if #(.W(DIN_W))  s_axis ();
    in256_out1536_pack_if #(.W(DOUT_W)) m_axis ();

    in256_out1536_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pack_num (pack_num),
        .s_axis   (s_axis),
        .m_axis   (m_axis)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    int timeouts = 0;
    int stalls = 0;
    int unstable = 0;
    bit rand_ready = 1'b0;

    word_t             exp_q[$];
    word_t             obs_q[$];
    logic [DIN_W-1:0]  cur_beats[$];
    int                cur_n = 6;
    logic              stall_q = 1'b0;
    logic [DOUT_W-1:0] stall_data;
    logic              stall_last;

    always @(posedge clk) cycle++;

    always @(posedge clk) if (rand_ready) #1 m_axis.tready = ($urandom_range(0, 3) != 0);

    // Reference model: collect accepted beats, emit a word after N beats or on tlast.
    always @(negedge clk) begin
        word_t w;
        if (!rst_n) begin
            cur_beats.delete();
            stall_q = 1'b0;
        end else begin
            if (s_axis.tvalid && !s_axis.tready) stalls++;
            if (s_axis.tvalid && s_axis.tready) begin
                if (cur_beats.size() == 0)
                    cur_n = (pack_num == 3'd0 || pack_num == 3'd7) ? 6 : int'(pack_num);
                cur_beats.push_back(s_axis.tdata);
                if (cur_beats.size() == cur_n || s_axis.tlast) begin
                    w.data = '0;
                    foreach (cur_beats[i]) w.data[i*DIN_W +: DIN_W] = cur_beats[i];
                    w.last = s_axis.tlast;
                    w.cyc  = cycle;
                    exp_q.push_back(w);
                    cur_beats.delete();
                end
            end
            if (stall_q && (!m_axis.tvalid || m_axis.tdata !== stall_data || m_axis.tlast !== stall_last))
                unstable++;
            stall_q    = m_axis.tvalid && !m_axis.tready;
            stall_data = m_axis.tdata;
            stall_last = m_axis.tlast;
            if (m_axis.tvalid && m_axis.tready) begin
                w.data = m_axis.tdata;
                w.last = m_axis.tlast;
                w.cyc  = cycle;
                obs_q.push_back(w);
            end
        end
    end

    function automatic logic [DIN_W-1:0] lane_fill(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {(DIN_W/8){b}};
    endfunction

    function automatic logic [DIN_W-1:0] rand_beat();
        logic [DIN_W-1:0] r;
        for (int i = 0; i < DIN_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int bad_lane(input logic [DOUT_W-1:0] a, input logic [DOUT_W-1:0] b);
        for (int k = 0; k < RATIO; k++)
            if (a[k*DIN_W +: DIN_W] !== b[k*DIN_W +: DIN_W]) return k;
        return 0;
    endfunction

    task automatic start_test();
        exp_q.delete();
        obs_q.delete();
        timeouts = 0;
        stalls   = 0;
        unstable = 0;
    endtask

    // Drive one beat from just after a rising edge; return just after the accepting edge.
    task automatic send_beat(input logic [DIN_W-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_axis.tready;
            @(posedge clk);
            #1;
        end
        if (!ok) timeouts++;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        pack_num      = 3'd6;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        m_axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m_axis.tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", m_axis.tvalid); end
        tests_run++;
        if (m_axis.tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b want 0", m_axis.tlast); end
        tests_run++;
        if (m_axis.tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata: nonzero lane %0d", bad_lane(m_axis.tdata, '0)); end
        tests_run++;
        if (s_axis.tready !== 1'b0) begin tests_failed++; $display("FAIL reset_tready: got %b want 0", s_axis.tready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_full_word();
        logic [DOUT_W-1:0] want;
        start_test();
        pack_num      = 3'd6;
        m_axis.tready = 1'b1;
        want = '0;
        for (int k = 0; k < 6; k++) begin
            want[k*DIN_W +: DIN_W] = lane_fill(k + 1);
            send_beat(lane_fill(k + 1), 1'b0);
        end
        drain();
        tests_run++;
        if (obs_q.size() !== 1) begin tests_failed++; $display("FAIL full_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            tests_run++;
            if (obs_q[0].data !== want) begin
                tests_failed++;
                $display("FAIL full_data lane %0d: got %h want %h", bad_lane(obs_q[0].data, want),
                         obs_q[0].data[bad_lane(obs_q[0].data, want)*DIN_W +: DIN_W],
                         want[bad_lane(obs_q[0].data, want)*DIN_W +: DIN_W]);
            end
            tests_run++;
            if (obs_q[0].last !== 1'b0) begin tests_failed++; $display("FAIL full_tlast: got %b want 0", obs_q[0].last); end
            tests_run++;
            if (obs_q[0].cyc - exp_q[0].cyc !== 1) begin
                tests_failed++; $display("FAIL full_latency: got %0d want 1", obs_q[0].cyc - exp_q[0].cyc);
            end
        end
        tests_run++;
        if (timeouts !== 0) begin tests_failed++; $display("FAIL full_timeout: got %0d want 0", timeouts); end
    endtask

    task automatic test_back_to_back();
        start_test();
        pack_num      = 3'd2;
        m_axis.tready = 1'b1;
        for (int k = 0; k < 6; k++) send_beat(rand_beat(), 1'b0);
        drain();
        tests_run++;
        if (obs_q.size() !== 3) begin tests_failed++; $display("FAIL b2b_count: got %0d want 3", obs_q.size()); end
        foreach (obs_q[i]) begin
            if (i < exp_q.size()) begin
                tests_run++;
                if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                    tests_failed++;
                    $display("FAIL b2b_word %0d lane %0d: got %h want %h", i, bad_lane(obs_q[i].data, exp_q[i].data),
                             obs_q[i].data[bad_lane(obs_q[i].data, exp_q[i].data)*DIN_W +: DIN_W],
                             exp_q[i].data[bad_lane(obs_q[i].data, exp_q[i].data)*DIN_W +: DIN_W]);
                end
            end
            tests_run++;
            if (obs_q[i].data[DOUT_W-1:2*DIN_W] !== '0) begin
                tests_failed++; $display("FAIL b2b_pad word %0d: nonzero upper lane %0d", i, bad_lane(obs_q[i].data, '0));
            end
            if (i > 0) begin
                tests_run++;
                if (obs_q[i].cyc - obs_q[i-1].cyc !== 2) begin
                    tests_failed++; $display("FAIL b2b_spacing word %0d: got %0d want 2", i, obs_q[i].cyc - obs_q[i-1].cyc);
                end
            end
        end
        tests_run++;
        if (stalls !== 0) begin tests_failed++; $display("FAIL b2b_tready: got %0d stalled cycles want 0", stalls); end
    endtask

    task automatic test_tlast_early();
        logic [DIN_W-1:0] beats[9];
        start_test();
        pack_num      = 3'd6;
        m_axis.tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            beats[k] = rand_beat();
            send_beat(beats[k], k == 2);
        end
        drain();
        tests_run++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            tests_failed++; $display("FAIL tlast_count: got %0d want 2", obs_q.size());
        end else begin
            tests_run++;
            if (obs_q[0].data !== exp_q[0].data) begin tests_failed++; $display("FAIL tlast_word0: lane %0d differs", bad_lane(obs_q[0].data, exp_q[0].data)); end
            tests_run++;
            if (obs_q[0].last !== 1'b1) begin tests_failed++; $display("FAIL tlast_flag: got %b want 1", obs_q[0].last); end
            tests_run++;
            if (obs_q[0].data[DOUT_W-1:3*DIN_W] !== '0) begin tests_failed++; $display("FAIL tlast_pad: upper lanes got nonzero want 0"); end
            tests_run++;
            if (obs_q[1].data[DIN_W-1:0] !== beats[3]) begin
                tests_failed++; $display("FAIL tlast_restart: lane0 got %h want %h", obs_q[1].data[DIN_W-1:0], beats[3]);
            end
            tests_run++;
            if (obs_q[1].data !== exp_q[1].data || obs_q[1].last !== 1'b0) begin
                tests_failed++; $display("FAIL tlast_word1: lane %0d differs, last got %b want 0", bad_lane(obs_q[1].data, exp_q[1].data), obs_q[1].last);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DIN_W-1:0] a, b, c;
        logic [DOUT_W-1:0] held;
        bit ok;
        start_test();
        a = rand_beat(); b = rand_beat(); c = rand_beat();
        held = '0;
        held[DIN_W-1:0] = a;
        pack_num      = 3'd1;
        m_axis.tready = 1'b0;
        send_beat(a, 1'b0);
        send_beat(b, 1'b0);
        s_axis.tdata  = c;
        s_axis.tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (s_axis.tready !== 1'b0) begin tests_failed++; $display("FAIL bp_tready cycle %0d: got %b want 0", i, s_axis.tready); end
            tests_run++;
            if (m_axis.tvalid !== 1'b1) begin tests_failed++; $display("FAIL bp_tvalid cycle %0d: got %b want 1", i, m_axis.tvalid); end
            tests_run++;
            if (m_axis.tdata !== held) begin
                tests_failed++; $display("FAIL bp_stable cycle %0d: lane0 got %h want %h", i, m_axis.tdata[DIN_W-1:0], a);
            end
        end
        @(posedge clk);
        #1 m_axis.tready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_axis.tready;
            @(posedge clk);
            #1;
        end
        s_axis.tvalid = 1'b0;
        drain();
        tests_run++;
        if (!ok || obs_q.size() !== 3) begin
            tests_failed++; $display("FAIL bp_count: got %0d want 3 (accepted %b)", obs_q.size(), ok);
        end else begin
            tests_run++;
            if (obs_q[0].data[DIN_W-1:0] !== a || obs_q[1].data[DIN_W-1:0] !== b || obs_q[2].data[DIN_W-1:0] !== c) begin
                tests_failed++;
                $display("FAIL bp_order: got %h,%h,%h want %h,%h,%h", obs_q[0].data[31:0], obs_q[1].data[31:0],
                         obs_q[2].data[31:0], a[31:0], b[31:0], c[31:0]);
            end
            tests_run++;
            if (obs_q[0].data[DOUT_W-1:DIN_W] !== '0 || obs_q[2].data[DOUT_W-1:DIN_W] !== '0) begin
                tests_failed++; $display("FAIL bp_pad: upper lanes got nonzero want 0");
            end
        end
    endtask

    task automatic test_pack_change();
        logic [DIN_W-1:0] beats[9];
        start_test();
        pack_num      = 3'd6;
        m_axis.tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 2) pack_num = 3'd3;
            beats[k] = rand_beat();
            send_beat(beats[k], 1'b0);
        end
        drain();
        tests_run++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            tests_failed++; $display("FAIL pchg_count: got %0d want 2", obs_q.size());
        end else begin
            tests_run++;
            if (obs_q[0].data[5*DIN_W +: DIN_W] !== beats[5]) begin
                tests_failed++; $display("FAIL pchg_lane5: got %h want %h", obs_q[0].data[5*DIN_W +: DIN_W], beats[5]);
            end
            tests_run++;
            if (obs_q[0].data !== exp_q[0].data) begin tests_failed++; $display("FAIL pchg_word0: lane %0d differs", bad_lane(obs_q[0].data, exp_q[0].data)); end
            tests_run++;
            if (obs_q[1].data !== exp_q[1].data) begin tests_failed++; $display("FAIL pchg_word1: lane %0d differs", bad_lane(obs_q[1].data, exp_q[1].data)); end
            tests_run++;
            if (obs_q[1].data[DOUT_W-1:3*DIN_W] !== '0) begin tests_failed++; $display("FAIL pchg_pad: upper lanes got nonzero want 0"); end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [DOUT_W-1:0] want;
        logic [DIN_W-1:0]  bt;
        start_test();
        pack_num      = 3'd6;
        m_axis.tready = 1'b1;
        for (int k = 0; k < 4; k++) send_beat(rand_beat(), 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== '0 || s_axis.tready !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_outputs: tvalid %b tready %b want 0 0 and zero data", m_axis.tvalid, s_axis.tready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_test();
        want = '0;
        for (int k = 0; k < 6; k++) begin
            bt = rand_beat();
            want[k*DIN_W +: DIN_W] = bt;
            send_beat(bt, 1'b0);
        end
        drain();
        tests_run++;
        if (obs_q.size() !== 1) begin
            tests_failed++; $display("FAIL rstmid_count: got %0d want 1", obs_q.size());
        end else begin
            tests_run++;
            if (obs_q[0].data !== want) begin
                tests_failed++;
                $display("FAIL rstmid_data lane %0d: got %h want %h", bad_lane(obs_q[0].data, want),
                         obs_q[0].data[bad_lane(obs_q[0].data, want)*DIN_W +: DIN_W],
                         want[bad_lane(obs_q[0].data, want)*DIN_W +: DIN_W]);
            end
        end
    endtask

    task automatic test_random();
        start_test();
        rand_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            pack_num = 3'($urandom_range(0, 7));
            send_beat(rand_beat(), $urandom_range(0, 4) == 0);
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #2 m_axis.tready = 1'b1;
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (obs_q[i]) begin
            if (i < exp_q.size()) begin
                tests_run++;
                if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                    tests_failed++;
                    $display("FAIL rand_word %0d: lane %0d differs, last got %b want %b", i,
                             bad_lane(obs_q[i].data, exp_q[i].data), obs_q[i].last, exp_q[i].last);
                end
            end
        end
        tests_run++;
        if (unstable !== 0) begin tests_failed++; $display("FAIL rand_stable: got %0d changes while stalled want 0", unstable); end
        tests_run++;
        if (timeouts !== 0) begin tests_failed++; $display("FAIL rand_timeout: got %0d want 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_tlast_early();
        test_backpressure();
        test_pack_change();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/in256_out1536_pack.md
Name: in256_out1536_pack

Overview:
- AXI-Stream width up-packer that assembles 256-bit beats into the 1536-bit words consumed by the five 1536-bit switch inputs (a-e) of the data-route crossbar.
- One instance per switch input.
- The number of beats per output word is programmable, so 256/512/.../1536-bit payloads map onto the fixed 1536-bit bus.
- Unused high lanes are zero-filled.

Parameters:
- DIN_W, 256, input beat width in bits.
- RATIO, 6, maximum beats per output word; DOUT_W = DIN_W*RATIO = 1536.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- pack_num  in  3  beats per output word; 1..6 valid; 0 and 7 treated as 6.
- s_axis_tdata  in  256  input beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  ends the current word early; remaining lanes are zero.
- m_axis_tdata  out  1536  packed word, to s_in_*_tdata.
- m_axis_tvalid  out  1  packed word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  word was closed by s_axis_tlast.

Behaviour:
- Reset is synchronous and active-low on clk. While rst_n=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, beat counter=0, assembly buffer=0, state=FILL.
- Lane mapping: beat k of a word (k=0 first) is written to bits [256*k +: 256]. Lanes >= beat count are 0 in the emitted word.
- pack_num is latched as N on acceptance of beat 0 of each word. Changes mid-word are ignored until the next word.
- A word closes on the accepted beat where cnt==N-1 OR s_axis_tlast=1, whichever comes first. tlast on beat 0 emits a single-lane word.
- State machine:
  - FILL: s_axis_tready=1. Each s_tvalid&s_tready writes a lane and increments cnt. On close: if the output register is free (m_tvalid=0 or m_tready=1 this cycle), move the word to the output register, clear the buffer and cnt, stay in FILL. Otherwise go to HOLD.
  - HOLD: s_axis_tready=0. When the output register frees (m_tvalid=0 or m_tready=1), transfer the word, clear the buffer and cnt, go to FILL.
- Buffer clearing: cleared lanes are zeroed so that short words are zero-padded.
- Latency: m_axis_tvalid rises on the clock edge that accepts the closing beat, i.e. the word is visible the cycle after that beat, provided the output register is free.
- Throughput: with m_axis_tready tied high, one output word per N input cycles with no input bubbles. The output register and the assembly buffer act as a 2-deep pipeline.
- AXIS output rules:
  - m_axis_tdata and m_axis_tlast are stable while m_tvalid & ~m_tready.
  - m_axis_tvalid deasserts only after a handshake with no new word pending.
- Simultaneous events: in the same cycle, the output handshake and a closing input beat give back-to-back words with no gap.
- s_axis_tready has no combinational path from s_axis_tvalid. It depends on state only (registered).
- Reset mid-word discards the partial word. Reset with a word held in the output register drops that word.
- m_axis_tlast = 1 iff the word was closed by s_axis_tlast, including when that beat was also beat N-1.

Decomposition:
- Shared package data_route_pkg holds:
  - DIN_W and RATIO constants;
  - the lane-index type (3 bits);
  - the FILL/HOLD state enum.
- Sub-module axis_out_reg: a 1536+1-bit AXIS holding register with load/free handshake. It is the natural split and is reusable ahead of the inter-switch 1536-bit inputs.
- Target size: 150-250 lines of RTL total.

Test Plan:
- pack_num=6, beats 0x01..0x06 (each lane filled with its index byte), m_ready=1 -> one word with lane k = byte k+1, tvalid 1 cycle after beat 6, tlast=0.
- pack_num=2, 6 continuous beats, m_ready=1 -> 3 words with lanes 2..5 = 0. s_tready stays 1 throughout; words appear every 2 cycles.
- pack_num=6, s_tlast on beat 3 -> lanes 0..2 carry data, lanes 3..5 = 0, m_tlast=1. The next word starts at lane 0.
- pack_num=1, m_ready=0 for 4 cycles -> word 1 is held in the output register, word 2 causes HOLD with s_tready=0, no further beats are accepted, and data stays stable. On m_ready=1, both words drain in order.
- pack_num changes 6->3 after beat 2 -> the current word still takes 6 beats; the following word takes 3.
- rst_n=0 after 4 of 6 beats, then 6 fresh beats -> no partial word is emitted; the first output contains only the fresh beats; all outputs read 0 during reset.
